// File: rtl/pixel_framebuffer_if.sv
// Host-stream and driver-side signal bundle for pixel_framebuffer.
// The master side is the byte source plus the WS2811 driver's address
// output; the slave side is the framebuffer itself.
interface pixel_framebuffer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] address;
  logic [7:0] red_out;
  logic [7:0] green_out;
  logic [7:0] blue_out;
  logic       swap_pending;
  logic       err;

  modport master (
    output in_data, in_valid, address,
    input  in_ready, red_out, green_out, blue_out, swap_pending, err
  );

  modport slave (
    input  in_data, in_valid, address,
    output in_ready, red_out, green_out, blue_out, swap_pending, err
  );
endinterface

// File: rtl/pixel_framebuffer.sv
// Double-buffered RGB pixel store feeding the WS2811 driver.
// Packets {A5, idx, count, (R,G,B) x count} fill the back bank; the banks
// swap only when the driver's address wraps to pixel 0, so frames never tear.
module pixel_framebuffer #(
  parameter int unsigned NUM_LEDS = 50
) (
  input logic               clk,
  input logic               reset,
  pixel_framebuffer_if.slave fb
);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_START,
    ST_COUNT,
    ST_RED,
    ST_GREEN,
    ST_BLUE
  } state_t;

  localparam int unsigned AW         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [8:0]  NUM_LEDS_W = 9'(NUM_LEDS);
  localparam logic [7:0]  LAST_IDX   = 8'(NUM_LEDS - 1);
  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;

  state_t      state_q, state_d;
  logic [7:0]  clr_idx_q;
  logic [7:0]  idx_q;
  logic [7:0]  remaining_q;
  logic [7:0]  red_q;
  logic [7:0]  green_q;
  logic [7:0]  prev_addr_q;
  logic        front_sel_q;
  logic        swap_pending_q, swap_pending_d;
  logic        in_ready_q;
  logic        err_q;
  logic [23:0] rgb_q;

  logic [23:0] bank0_q [NUM_LEDS];
  logic [23:0] bank1_q [NUM_LEDS];

  logic          accept;
  logic          wrap;
  logic          swap_now;
  logic          frame_done;
  logic          clear_wr;
  logic          pix_wr;
  logic          wr0, wr1;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [AW-1:0] rd_addr;
  logic          rd_sel;
  logic          rd_valid;
  logic [23:0]   rd_data;

  assign accept     = fb.in_valid && in_ready_q;
  assign wrap       = (fb.address == 8'd0) && (prev_addr_q != 8'd0);
  assign swap_now   = wrap && swap_pending_q;
  assign frame_done = (state_q == ST_BLUE) && accept && (remaining_q == 8'd1);
  // A frame can only complete while nothing is pending, so set and clear never collide.
  assign swap_pending_d = frame_done || (swap_pending_q && !swap_now);

  // Write port: CLEAR zeroes both banks together, BLUE writes the back bank.
  assign clear_wr = (state_q == ST_CLEAR);
  assign pix_wr   = (state_q == ST_BLUE) && accept && ({1'b0, idx_q} < NUM_LEDS_W);
  assign wr_addr  = clear_wr ? clr_idx_q[AW-1:0] : idx_q[AW-1:0];
  assign wr_data  = clear_wr ? 24'd0 : {red_q, green_q, fb.in_data};
  assign wr0      = reset && (clear_wr || (pix_wr &&  front_sel_q));
  assign wr1      = reset && (clear_wr || (pix_wr && !front_sel_q));

  // Read port: on the swapping wrap the new front bank is already selected.
  assign rd_addr  = fb.address[AW-1:0];
  assign rd_sel   = front_sel_q ^ swap_now;
  assign rd_valid = (state_q != ST_CLEAR) && ({1'b0, fb.address} < NUM_LEDS_W);
  assign rd_data  = rd_sel ? bank1_q[rd_addr] : bank0_q[rd_addr];

  // Packet parser next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_idx_q == LAST_IDX) state_d = ST_IDLE;
      ST_IDLE:  if (accept && (fb.in_data == SYNC_BYTE)) state_d = ST_START;
      ST_START: if (accept) state_d = ST_COUNT;
      ST_COUNT: if (accept) state_d = (fb.in_data == 8'd0) ? ST_IDLE : ST_RED;
      ST_RED:   if (accept) state_d = ST_GREEN;
      ST_GREEN: if (accept) state_d = ST_BLUE;
      ST_BLUE:  if (accept) state_d = (remaining_q == 8'd1) ? ST_IDLE : ST_RED;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Pixel storage.
  // NOTE: no reset term here; CLEAR walks every index instead, so the banks stay RAM-mappable.
  always_ff @(posedge clk) begin
    if (wr0) bank0_q[wr_addr] <= wr_data;
    if (wr1) bank1_q[wr_addr] <= wr_data;
  end

  // FSM state, packet datapath, swap control and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_CLEAR;
      clr_idx_q      <= 8'd0;
      idx_q          <= 8'd0;
      remaining_q    <= 8'd0;
      red_q          <= 8'd0;
      green_q        <= 8'd0;
      prev_addr_q    <= 8'd0;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      in_ready_q     <= 1'b0;
      err_q          <= 1'b0;
      rgb_q          <= 24'd0;
    end else begin
      state_q        <= state_d;
      prev_addr_q    <= fb.address;
      swap_pending_q <= swap_pending_d;
      if (swap_now) front_sel_q <= !front_sel_q;

      // Ready is registered from the next state so it is valid at the start of each cycle.
      if (state_d == ST_CLEAR)     in_ready_q <= 1'b0;
      else if (state_d == ST_IDLE) in_ready_q <= !swap_pending_d;
      else                         in_ready_q <= 1'b1;

      err_q <= (state_q == ST_COUNT) && accept && (fb.in_data == 8'd0);
      rgb_q <= rd_valid ? rd_data : 24'd0;

      if (state_q == ST_CLEAR) clr_idx_q <= clr_idx_q + 8'd1;

      if (accept) begin
        case (state_q)
          ST_START: idx_q <= fb.in_data;
          ST_COUNT: if (fb.in_data != 8'd0) remaining_q <= fb.in_data;
          ST_RED:   red_q <= fb.in_data;
          ST_GREEN: green_q <= fb.in_data;
          ST_BLUE: begin
            if (idx_q != 8'hFF) idx_q <= idx_q + 8'd1;
            remaining_q <= remaining_q - 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign fb.in_ready     = in_ready_q;
  assign fb.red_out      = rgb_q[23:16];
  assign fb.green_out    = rgb_q[15:8];
  assign fb.blue_out     = rgb_q[7:0];
  assign fb.swap_pending = swap_pending_q;
  assign fb.err          = err_q;

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Directed testbench for pixel_framebuffer with NUM_LEDS = 50.
module tb_pixel_framebuffer;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  pixel_framebuffer_if bus ();

  pixel_framebuffer #(.NUM_LEDS(50)) dut (
    .clk   (clk),
    .reset (reset),
    .fb    (bus)
  );

  logic [23:0] rgb;
  assign rgb = {bus.red_out, bus.green_out, bus.blue_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte, wait (bounded) for ready, transfer it on the next edge.
  task automatic send(input logic [7:0] b);
    int waited;
    waited = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 200) begin
      tick();
      waited++;
    end
    check("send_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic set_addr(input logic [7:0] a);
    bus.address = a;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    bus.in_data  = 8'd0;
    bus.in_valid = 1'b0;
    bus.address  = 8'd0;

    // Reset held for 3 cycles.
    repeat (3) tick();
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_pending", 32'(bus.swap_pending), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_rgb", 32'(rgb), 32'd0);

    // CLEAR lasts exactly 50 cycles.
    reset = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      check($sformatf("clear_ready_%0d", c), 32'(bus.in_ready), (c == 50) ? 32'd1 : 32'd0);
    end

    // Front bank reads all zeros.
    for (int a = 0; a < 50; a++) begin
      set_addr(8'(a));
      check($sformatf("sweep_%0d", a), 32'(rgb), 32'd0);
    end

    // Full frame: pixels 0 and 1 into the back bank.
    set_addr(8'd0);
    check("ff_old0", 32'(rgb), 32'd0);
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h10); send(8'h20); send(8'h30);
    send(8'h40); send(8'h50); send(8'h60);
    check("ff_pending", 32'(bus.swap_pending), 32'd1);
    check("ff_ready_low", 32'(bus.in_ready), 32'd0);

    // Stall: A5 held while a swap is pending.
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    bus.address  = 8'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ready", 32'(bus.in_ready), 32'd0);
      check("stall_pending", 32'(bus.swap_pending), 32'd1);
      check("stall_old5", 32'(rgb), 32'd0);
    end
    bus.address = 8'd0;
    tick();
    check("wrap_new0", 32'(rgb), 32'h102030);
    check("wrap_pending", 32'(bus.swap_pending), 32'd0);
    check("wrap_ready", 32'(bus.in_ready), 32'd1);
    bus.address = 8'd1;
    tick();
    check("new1", 32'(rgb), 32'h405060);
    bus.in_valid = 1'b0;
    bus.address  = 8'd2;
    send(8'h03);
    check("new2_cleared", 32'(rgb), 32'd0);
    send(8'h01); send(8'hFF); send(8'hEE); send(8'hDD);
    check("stalled_pkt_pending", 32'(bus.swap_pending), 32'd1);
    set_addr(8'd3);
    check("pre_swap3", 32'(rgb), 32'd0);
    set_addr(8'd0);
    check("swap2_0", 32'(rgb), 32'd0);
    check("swap2_pending", 32'(bus.swap_pending), 32'd0);
    set_addr(8'd3);
    check("swap2_3", 32'(rgb), 32'hFFEEDD);

    // Stray byte dropped, then zero-count packet rejected.
    set_addr(8'd0);
    send(8'h42);
    send(8'hA5); send(8'h05); send(8'h00);
    check("bad_err_pulse", 32'(bus.err), 32'd1);
    tick();
    check("bad_err_clear", 32'(bus.err), 32'd0);
    check("bad_pending", 32'(bus.swap_pending), 32'd0);

    // Pixel 49 written, pixel 50 discarded.
    send(8'hA5); send(8'h31); send(8'h02);
    send(8'h01); send(8'h02); send(8'h03);
    send(8'h04); send(8'h05); send(8'h06);
    check("oor_err", 32'(bus.err), 32'd0);
    check("oor_pending", 32'(bus.swap_pending), 32'd1);
    set_addr(8'd49);
    check("oor_old49", 32'(rgb), 32'd0);
    set_addr(8'd0);
    check("oor_keep0", 32'(rgb), 32'h102030);
    set_addr(8'd49);
    check("oor_new49", 32'(rgb), 32'h010203);
    set_addr(8'd1);
    check("oor_keep1", 32'(rgb), 32'h405060);
    set_addr(8'd50);
    check("oor_addr50", 32'(rgb), 32'd0);

    // Final BLUE byte on the exact wrap cycle.
    set_addr(8'd7);
    send(8'hA5); send(8'h02); send(8'h01); send(8'hAA); send(8'hBB);
    bus.address = 8'd0;
    send(8'hCC);
    check("coin_pending", 32'(bus.swap_pending), 32'd1);
    check("coin_no_swap", 32'(rgb), 32'h102030);
    tick();
    check("idle0_pending", 32'(bus.swap_pending), 32'd1);
    check("idle0_no_swap", 32'(rgb), 32'h102030);
    set_addr(8'd4);
    set_addr(8'd0);
    check("coin_swap0", 32'(rgb), 32'd0);
    check("coin_swap_pending", 32'(bus.swap_pending), 32'd0);
    set_addr(8'd2);
    check("coin_swap2", 32'(rgb), 32'hAABBCC);

    // Reset in the middle of a packet.
    set_addr(8'd0);
    send(8'hA5); send(8'h00); send(8'h03); send(8'h11);
    reset = 1'b0;
    tick();
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    check("mid_rst_pending", 32'(bus.swap_pending), 32'd0);
    check("mid_rst_rgb", 32'(rgb), 32'd0);
    check("mid_rst_err", 32'(bus.err), 32'd0);
    reset = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      check($sformatf("reclear_ready_%0d", c), 32'(bus.in_ready), (c == 50) ? 32'd1 : 32'd0);
    end
    set_addr(8'd5);
    set_addr(8'd0);
    check("post_rst_pending", 32'(bus.swap_pending), 32'd0);
    check("post_rst_rgb", 32'(rgb), 32'd0);
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'h12); send(8'h34); send(8'h56);
    check("post_rst_frame_pending", 32'(bus.swap_pending), 32'd1);
    set_addr(8'd5);
    set_addr(8'd0);
    check("post_rst_frame0", 32'(rgb), 32'h123456);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pixel_framebuffer.md
# pixel_framebuffer

Double-buffered RGB pixel store that sits directly upstream of the WS2811 serial driver. It replaces the procedural colour generator when the strip is host-driven. A byte stream, typically from a UART receiver, writes pixels into a back bank. The driver's `address` output reads the front bank. Banks swap only at the driver's wrap to pixel 0, so a displayed frame never tears.

## Interface
- `NUM_LEDS`, 50: pixels per bank, range 1..255.
- `clk` in 1: system clock (PLL output).
- `reset` in 1: synchronous, active-low reset.
- `in_data` in 8: host stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block accepts a byte this cycle. A byte transfers when `in_valid && in_ready`.
- `address` in 8: pixel index requested by the driver.
- `red_out` out 8: front-bank red component, feeds the driver's `red_in`.
- `green_out` out 8: front-bank green component, feeds `green_in`.
- `blue_out` out 8: front-bank blue component, feeds `blue_in`.
- `swap_pending` out 1: a completed frame is waiting for the next wrap.
- `err` out 1: one-cycle pulse when a packet is rejected.

## Operation
- **Storage:** two banks of `NUM_LEDS` x 24 bits (R, G, B). `front_sel` selects the displayed bank; the other bank is the back bank.
- **States:** CLEAR, IDLE, START, COUNT, RED, GREEN, BLUE.
- **CLEAR:**
  - Entered on reset.
  - Writes 0 to index k of both banks, k = 0..NUM_LEDS-1, one index per cycle.
  - `in_ready` = 0 throughout.
  - Moves to IDLE after index NUM_LEDS-1.
- **IDLE:**
  - `in_ready` = !swap_pending.
  - Byte 0xA5 moves to START. Any other byte is dropped with no `err`.
- **START:** the accepted byte is latched as `idx`; move to COUNT.
- **COUNT:**
  - Accepted byte 0: pulse `err`, return to IDLE.
  - Any other value n: latch `remaining` = n, move to RED.
- **RED, GREEN:** latch the component and advance to the next colour state.
- **BLUE:**
  - Write {r, g, b} to back[idx] only if idx < NUM_LEDS. Out-of-range pixels are consumed and discarded, with no `err`.
  - Then `idx` += 1, saturating at 255, and `remaining` -= 1.
  - If `remaining` was 1: set `swap_pending`, go to IDLE. Otherwise go to RED.
- **`in_ready`:** 1 in START, COUNT, RED, GREEN and BLUE.
- **Wrap detect:** register `prev_addr`. `wrap` = (address == 0) && (prev_addr != 0).
- **Swap:** when `wrap && swap_pending`, toggle `front_sel` and clear `swap_pending`.
- **Partial frames:** pixels not written in a frame keep the back bank's existing contents, i.e. the frame shown two swaps earlier.
- **Read path:**
  - Registered. `{red_out, green_out, blue_out}` at t+1 = bank[front_sel ^ swap_now][address at t].
  - Equals 0 if `address` >= NUM_LEDS or if the block is in CLEAR.

## Timing
- **Reset values:** red_out/green_out/blue_out = 0, in_ready = 0, swap_pending = 0, err = 0, front_sel = 0, prev_addr = 0, state = CLEAR.
- **Reset mid-packet or mid-clear:** abandons all progress, re-enters CLEAR, and restarts at index 0.
- **CLEAR duration:** exactly NUM_LEDS cycles. The first byte can be accepted on cycle NUM_LEDS after reset deasserts.
- **Read latency:** 1 cycle. On the wrap cycle that swaps, pixel 0 is already read from the new bank.
- **Write latency:** the BLUE byte is accepted at t; the pixel is in back[idx] at t+1. It becomes visible only after the swap.
- **`swap_pending` set on a wrap cycle:** if the final BLUE byte is accepted in the same cycle as a wrap, `swap_pending` is set and the swap waits for the next wrap.
- **Back-pressure:** while `swap_pending` = 1, `in_ready` = 0 in IDLE only, so a new packet's 0xA5 stalls. A packet already past IDLE cannot exist, because `swap_pending` sets only on the transition into IDLE.
- **Idle address:** if `address` stays at 0, `wrap` does not re-fire.
- **Bandwidth:** one byte per cycle sustained inside a packet.

## Test plan
- **Reset/clear:** hold `reset` = 0 for 3 cycles, then release with NUM_LEDS = 50 → `in_ready` = 0 for 50 cycles, then 1. Sweeping address 0..49 reads all zeros.
- **Full frame:** send A5, 00, 02, 10, 20, 30, 40, 50, 60, then driver address 5 → 0 → 1 → `swap_pending` = 1 until the wrap. Address 0 then reads 10/20/30 and address 1 reads 40/50/60; the old bank showed 0s before the wrap.
- **Stall:** with `swap_pending` = 1, hold 0xA5 valid → `in_ready` = 0 and no state change. After the wrap the byte is accepted next cycle.
- **Bad packets:** A5, 05, 00 → `err` pulses once, state IDLE, nothing written. A5, 31, 02 followed by 6 bytes (NUM_LEDS = 50) → pixel 49 written, pixel 50 discarded, no `err`.
- **Coincident events:** final BLUE byte accepted on the exact wrap cycle → `front_sel` unchanged that cycle; swap occurs at the following wrap.
- **Reset mid-packet:** assert `reset` after A5, 00, 03, 11 → CLEAR restarts, `swap_pending` = 0, and the next wrap causes no swap.
